// File: rtl/seven_seg_capture.sv
// Debounced decoder for a scanned seven-segment bus; emits one nibble frame per scan.
// Define SSEG_ACTIVE_LOW_EN for common-anode (active-low) segment/select lines.
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [6:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_digit_sel,
  input  logic                    i_frame_ready,
  output logic [4*NUM_DIGITS-1:0] o_frame,
  output logic [NUM_DIGITS-1:0]   o_dash_mask,
  output logic                    o_frame_valid,
  output logic                    o_err,
  output logic                    o_overrun
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CAP_CNT = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] MAX_CNT = CW'(STABLE_CYCLES);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {IDLE, COUNT, LOCKED} state_t;

  logic [SW-1:0]           w_raw;
  logic [SW-1:0]           r_sync1;
  logic [SW-1:0]           r_samp;
  logic [SW-1:0]           r_prev;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [6:0]              w_seg;
  logic                    w_same;
  logic                    w_onehot;
  logic                    w_capture;
  logic [3:0]              w_hex;
  logic                    w_is_hex;
  logic                    w_is_dash;
  logic                    w_legal;
  logic                    w_write;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;
  logic [4*NUM_DIGITS-1:0] r_work;
  logic [NUM_DIGITS-1:0]   r_dash;
  logic                    w_complete;
  logic                    w_load;
  logic [4*NUM_DIGITS-1:0] r_frame;
  logic [NUM_DIGITS-1:0]   r_dmask;
  logic                    r_valid;
  logic                    r_err;
  logic                    r_ovr;

`ifdef SSEG_ACTIVE_LOW_EN
  assign w_raw = ~{i_digit_sel, i_seg};
`else
  assign w_raw = {i_digit_sel, i_seg};
`endif

  assign w_sel    = r_samp[SW-1:7];
  assign w_seg    = r_samp[6:0];
  assign w_same   = r_samp == r_prev;
  assign w_onehot = (w_sel != '0) &&
                    ((w_sel & (w_sel - 1'b1)) == '0);

  assign w_cnt_nxt = !w_same            ? '0    :
                     (r_cnt == MAX_CNT) ? r_cnt :
                     r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_onehot) w_state_nxt = COUNT;
      end
      COUNT: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
        end else if (w_same && r_cnt == CAP_CNT) begin
          w_capture   = 1'b1;
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (!w_onehot)   w_state_nxt = IDLE;
        else if (!w_same) w_state_nxt = COUNT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_hex    = 4'h0;
    w_is_hex = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (w_seg == SEG_LUT[i]) begin
        w_hex    = 4'(i);
        w_is_hex = 1'b1;
      end
    end
  end

  assign w_is_dash  = w_seg == 7'b0000001;
  assign w_legal    = w_is_hex | w_is_dash;
  assign w_write    = w_capture & w_legal;
  assign w_complete = &r_seen;
  assign w_load     = w_complete & (~r_valid | i_frame_ready);
  assign w_seen_nxt = (w_complete ? '0 : r_seen) |
                      (w_write ? w_sel : '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_samp  <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_seen  <= '0;
      r_work  <= '0;
      r_dash  <= '0;
      r_frame <= '0;
      r_dmask <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= w_raw;
      r_samp  <= r_sync1;
      r_prev  <= r_samp;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_seen  <= w_seen_nxt;
      r_err   <= w_capture & ~w_legal;
      r_ovr   <= w_complete & r_valid & ~i_frame_ready;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_write && w_sel[k]) begin
          r_work[4*k +: 4] <= w_hex;
          r_dash[k]        <= w_is_dash;
        end
      end
      if (w_load) begin
        r_frame <= r_work;
        r_dmask <= r_dash;
        r_valid <= 1'b1;
      end else if (r_valid && i_frame_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_frame       = r_frame;
  assign o_dash_mask   = r_dmask;
  assign o_frame_valid = r_valid;
  assign o_err         = r_err;
  assign o_overrun     = r_ovr;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed vector table, corner sequences, random vs model.
// Build with SSEG_ACTIVE_LOW_EN to drive the inverted buses with the same expectations.
module tb_seven_seg_capture;

  localparam int N  = 4;
  localparam int SC = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [6:0]    i_seg;
  logic [N-1:0]  i_digit_sel;
  logic          i_frame_ready;
  logic [4*N-1:0] o_frame;
  logic [N-1:0]  o_dash_mask;
  logic          o_frame_valid;
  logic          o_err;
  logic          o_overrun;

  seven_seg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_seg(i_seg),
    .i_digit_sel(i_digit_sel),
    .i_frame_ready(i_frame_ready),
    .o_frame(o_frame),
    .o_dash_mask(o_dash_mask),
    .o_frame_valid(o_frame_valid),
    .o_err(o_err),
    .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int n_err;
  int n_ovr;
  int nprint = 0;

  logic [6:0] codes [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    int          hold;
    logic        rdy;
    logic        cd;
    logic        valid;
    logic [15:0] frame;
    logic [3:0]  dash;
    int          errs;
    int          ovrs;
  } row_t;

  row_t rows [28];

  typedef struct {
    int         e;
    logic [3:0] sel;
    logic [6:0] seg;
  } cap_t;

  cap_t q[$];

  logic [15:0] m_work, m_frame;
  logic [3:0]  m_dmask, m_dash, m_seen;
  logic        m_valid, m_err, m_ovr;

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
`ifdef SSEG_ACTIVE_LOW_EN
    i_digit_sel = ~sel;
    i_seg       = ~seg;
`else
    i_digit_sel = sel;
    i_seg       = seg;
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_err) n_err++;
      if (o_overrun) n_ovr++;
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      drive(rows[r].sel, rows[r].seg);
      i_frame_ready = rows[r].rdy;
      n_err = 0;
      n_ovr = 0;
      step(rows[r].hold);
      chk($sformatf("row%0d valid", r), 32'(o_frame_valid), 32'(rows[r].valid));
      if (rows[r].cd) begin
        chk($sformatf("row%0d frame", r), 32'(o_frame), 32'(rows[r].frame));
        chk($sformatf("row%0d dash", r), 32'(o_dash_mask), 32'(rows[r].dash));
      end
      chk($sformatf("row%0d err_pulses", r), 32'(n_err), 32'(rows[r].errs));
      chk($sformatf("row%0d ovr_pulses", r), 32'(n_ovr), 32'(rows[r].ovrs));
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive(4'h0, 7'h00);
    i_frame_ready = 1'b0;
    step(3);
    chk("reset valid", 32'(o_frame_valid), 32'd0);
    chk("reset frame", 32'(o_frame), 32'd0);
    chk("reset dash", 32'(o_dash_mask), 32'd0);
    chk("reset pulses", 32'({o_err, o_overrun}), 32'd0);
    i_rst = 1'b0;
    step(2);
  endtask

  function automatic int lut(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  // Reference: frame buffer rules applied at one clock edge.
  task automatic model_edge(input int e, input logic rdy);
    int   idx;
    cap_t c;
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (m_seen == 4'hF) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_frame = m_work;
        m_dash  = m_dmask;
      end else begin
        m_ovr = 1'b1;
      end
      m_seen = 4'h0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (q.size() > 0 && q[0].e == e) begin
      c   = q.pop_front();
      idx = lut(c.seg);
      if (idx < 0 && c.seg != 7'b0000001) begin
        m_err = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (c.sel[k]) begin
            m_work[4*k +: 4] = (idx < 0) ? 4'h0 : 4'(idx);
            m_dmask[k] = (idx < 0);
            m_seen[k]  = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    rows[0]  = '{4'h1, 7'h7E, 20, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[1]  = '{4'h2, 7'h30, 20, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[2]  = '{4'h4, 7'h77, 20, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[3]  = '{4'h8, 7'h47, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[4]  = '{4'h1, 7'h5B, 15, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[5]  = '{4'h1, 7'h00, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 1, 0};
    rows[6]  = '{4'h2, 7'h79, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[7]  = '{4'h4, 7'h5F, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[8]  = '{4'h8, 7'h7B, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[9]  = '{4'h1, 7'h01, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 1};
    rows[10] = '{4'h1, 7'h4E, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[11] = '{4'h2, 7'h3D, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[12] = '{4'h4, 7'h4F, 20, 1'b0, 1'b1, 1'b1, 16'hFA10, 4'h0, 0, 0};
    rows[13] = '{4'h1, 7'h01, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[14] = '{4'h2, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[15] = '{4'h4, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[16] = '{4'h8, 7'h30, 20, 1'b0, 1'b1, 1'b1, 16'h1110, 4'h1, 0, 0};
    rows[17] = '{4'h3, 7'h7E, 40, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[18] = '{4'h2, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[19] = '{4'h4, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[20] = '{4'h8, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[21] = '{4'h1, 7'h6D, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[22] = '{4'h2, 7'h5B, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[23] = '{4'h4, 7'h7F, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[24] = '{4'h8, 7'h1F, 20, 1'b0, 1'b1, 1'b1, 16'hB852, 4'h0, 0, 0};
    rows[25] = '{4'h1, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[26] = '{4'h2, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};
    rows[27] = '{4'h4, 7'h30, 20, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 0, 0};

    i_rst = 1'b1;
    i_frame_ready = 1'b0;
    drive(4'h0, 7'h00);
    n_err = 0;
    n_ovr = 0;
    do_reset();

    run_rows(0, 12);

    // Third frame completes on the very cycle the held frame is accepted.
    drive(4'h8, 7'h1F);
    n_ovr = 0;
    step(18);
    chk("pre_accept valid", 32'(o_frame_valid), 32'd1);
    chk("pre_accept frame", 32'(o_frame), 32'hFA10);
    i_frame_ready = 1'b1;
    step(1);
    i_frame_ready = 1'b0;
    chk("swap valid", 32'(o_frame_valid), 32'd1);
    chk("swap frame", 32'(o_frame), 32'hBEDC);
    chk("swap dash", 32'(o_dash_mask), 32'd0);
    chk("swap no_overrun", 32'(n_ovr), 32'd0);
    step(1);
    chk("hold frame", 32'(o_frame), 32'hBEDC);
    i_frame_ready = 1'b1;
    step(1);
    i_frame_ready = 1'b0;
    chk("drain valid", 32'(o_frame_valid), 32'd0);

    run_rows(13, 20);
    do_reset();
    run_rows(21, 24);
    i_frame_ready = 1'b1;
    step(1);
    i_frame_ready = 1'b0;
    chk("drain2 valid", 32'(o_frame_valid), 32'd0);
    run_rows(25, 27);

    // Latency: last digit applied at edge 0, valid expected at edge 3+SC.
    drive(4'h8, 7'h30);
    step(SC + 2);
    chk("latency early", 32'(o_frame_valid), 32'd0);
    step(1);
    chk("latency valid", 32'(o_frame_valid), 32'd1);
    chk("latency frame", 32'(o_frame), 32'h1111);

    do_reset();
    begin
      int         e;
      int         left;
      int         len;
      int         rp;
      logic       rdy;
      logic       bad;
      logic [3:0] sel, psel;
      logic [6:0] seg, pseg;
      e = 0;
      left = 0;
      psel = 4'h0;
      pseg = 7'h00;
      m_work = '0; m_frame = '0; m_dmask = '0; m_dash = '0;
      m_seen = '0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if (left == 0) begin
          do begin
            if ($urandom_range(0, 99) < 85) sel = 4'(1 << $urandom_range(0, 3));
            else sel = 4'($urandom_range(0, 15));
            len = $urandom_range(0, 99);
            if (len < 70) seg = codes[$urandom_range(0, 15)];
            else if (len < 80) seg = 7'b0000001;
            else seg = 7'($urandom_range(0, 127));
          end while ({sel, seg} == {psel, pseg});
          if ($urandom_range(0, 99) < 60) len = $urandom_range(SC, 30);
          else len = $urandom_range(2, SC + 2);
          drive(sel, seg);
          if ($countones(sel) == 1 && len >= SC)
            q.push_back('{e + SC + 2, sel, seg});
          psel = sel;
          pseg = seg;
          left = len;
        end
        left--;
        case ((c / 500) % 3)
          0: rp = 2;
          1: rp = 30;
          default: rp = 90;
        endcase
        rdy = ($urandom_range(0, 99) < rp);
        i_frame_ready = rdy;
        @(posedge i_clk);
        e++;
        model_edge(e, rdy);
        @(negedge i_clk);
        checks++;
        bad = (o_frame_valid !== m_valid) || (o_err !== m_err) ||
              (o_overrun !== m_ovr) ||
              (m_valid && (o_frame !== m_frame || o_dash_mask !== m_dash));
        if (bad) begin
          failures++;
          if (nprint < 10)
            $display("FAIL random cyc%0d v/e/o/frame/dash got %b%b%b %h %b expected %b%b%b %h %b",
                     c, o_frame_valid, o_err, o_overrun, o_frame, o_dash_mask,
                     m_valid, m_err, m_ovr, m_frame, m_dash);
          nprint++;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
